// File: rtl/lane_key_conditioner.sv
// Lane button conditioner: per-lane two-flop synchroniser, debounce FSM and
// registered press/release pulses, plus a lowest-lane-wins encoder for the hit register.

module lane_key_conditioner_lane #(
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 18
) (
  input  logic C_i,
  input  logic clr_i,
  input  logic s_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_ON  = 2'd1,
    HELD    = 2'd2,
    ARM_OFF = 2'd3
  } laneState_e;

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(DEB_CYCLES - 1);

  laneState_e       state_q;
  laneState_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  always_ff @(posedge C_i) begin
    if (clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // The counter restarts on every state change and stops at LastCount, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s_i) begin
          state_d = ARM_ON;
          cnt_d   = '0;
        end
      end
      ARM_ON: begin
        if (!s_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LastCount) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s_i) begin
          state_d = ARM_OFF;
          cnt_d   = '0;
        end
      end
      ARM_OFF: begin
        if (s_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == LastCount) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d = (state_d == HELD) || (state_d == ARM_OFF);
    rise_o  = (state_q == ARM_ON)  && (state_d == HELD);
    fall_o  = (state_q == ARM_OFF) && (state_d == IDLE);
  end

  assign level_o = level_q;

endmodule

module lane_key_conditioner #(
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 18
) (
  input  logic       C_i,
  input  logic       clr_i,
  input  logic [3:0] btn_i,
  input  logic       en_i,
  output logic [3:0] level_o,
  output logic [3:0] press_o,
  output logic [3:0] release_o,
  output logic       hit_any_o,
  output logic [1:0] lane_code_o
);

  logic [3:0] syncMeta_q;
  logic [3:0] syncOut_q;
  logic [3:0] laneRise;
  logic [3:0] laneFall;
  logic [3:0] press_q;
  logic [3:0] press_d;
  logic [3:0] release_q;
  logic [3:0] release_d;
  logic       hitAny_q;
  logic       hitAny_d;
  logic [1:0] laneCode_q;
  logic [1:0] laneCode_d;

  always_ff @(posedge C_i) begin
    if (clr_i) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
    end else begin
      syncMeta_q <= btn_i;
      syncOut_q  <= syncMeta_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_key_conditioner_lane #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_lane (
      .C_i    (C_i),
      .clr_i  (clr_i),
      .s_i    (syncOut_q[i]),
      .level_o(level_o[i]),
      .rise_o (laneRise[i]),
      .fall_o (laneFall[i])
    );
  end

  // Events are gated by en on the edge that registers them, so a masked event is simply lost.
  always_comb begin
    press_d    = laneRise & {4{en_i}};
    release_d  = laneFall & {4{en_i}};
    hitAny_d   = |press_d;
    laneCode_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press_d[i]) begin
        laneCode_d = 2'(i);
      end
    end
  end

  always_ff @(posedge C_i) begin
    if (clr_i) begin
      press_q    <= '0;
      release_q  <= '0;
      hitAny_q   <= 1'b0;
      laneCode_q <= 2'd0;
    end else begin
      press_q    <= press_d;
      release_q  <= release_d;
      hitAny_q   <= hitAny_d;
      laneCode_q <= laneCode_d;
    end
  end

  assign press_o     = press_q;
  assign release_o   = release_q;
  assign hit_any_o   = hitAny_q;
  assign lane_code_o = laneCode_q;

endmodule

// File: tb/tb_lane_key_conditioner.sv
// Directed bench for lane_key_conditioner with DEB_CYCLES=4: every event must land
// exactly 7 edges after the input change that causes it.

module tb_lane_key_conditioner;

  logic       C_i;
  logic       clr_i;
  logic [3:0] btn_i;
  logic       en_i;
  logic [3:0] level_o;
  logic [3:0] press_o;
  logic [3:0] release_o;
  logic       hit_any_o;
  logic [1:0] lane_code_o;

  int assertCount = 0;
  int failCount   = 0;

  lane_key_conditioner #(
    .DEB_CYCLES(4),
    .CNT_W     (3)
  ) dut (
    .C_i        (C_i),
    .clr_i      (clr_i),
    .btn_i      (btn_i),
    .en_i       (en_i),
    .level_o    (level_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .hit_any_o  (hit_any_o),
    .lane_code_o(lane_code_o)
  );

  initial C_i = 1'b0;
  always #5 C_i = ~C_i;

  task automatic step();
    @(posedge C_i);
    @(negedge C_i);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    clr_i = 1'b1; btn_i = 4'hF; en_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      assertCount++;
      if ({level_o, press_o, release_o, hit_any_o, lane_code_o} !== 15'd0) begin
        failCount++;
        $display("[TB] FAIL reset_outputs: got %b expected all zero",
                 {level_o, press_o, release_o, hit_any_o, lane_code_o});
      end
    end
    clr_i = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (press_o !== ((n == 7) ? 4'hF : 4'h0) || level_o !== ((n >= 7) ? 4'hF : 4'h0)) begin
        failCount++;
        $display("[TB] FAIL reset_press edge %0d: press=%b level=%b, expected press=%b level=%b",
                 n, press_o, level_o, (n == 7) ? 4'hF : 4'h0, (n >= 7) ? 4'hF : 4'h0);
      end
      assertCount++;
      if (hit_any_o !== (n == 7) || lane_code_o !== 2'd0) begin
        failCount++;
        $display("[TB] FAIL reset_hit edge %0d: hit_any=%b lane_code=%0d, expected %b/0",
                 n, hit_any_o, lane_code_o, (n == 7));
      end
    end
    btn_i = 4'h0;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (release_o !== ((n == 7) ? 4'hF : 4'h0) || level_o !== ((n >= 7) ? 4'h0 : 4'hF)) begin
        failCount++;
        $display("[TB] FAIL reset_release edge %0d: release=%b level=%b", n, release_o, level_o);
      end
    end
  endtask

  task automatic test_single_press();
    $display("[TB] test_single_press");
    btn_i = 4'b0100;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (press_o !== ((n == 7) ? 4'b0100 : 4'b0000) || level_o !== ((n >= 7) ? 4'b0100 : 4'b0000)
          || release_o !== 4'b0000) begin
        failCount++;
        $display("[TB] FAIL single_press edge %0d: press=%b level=%b release=%b",
                 n, press_o, level_o, release_o);
      end
      assertCount++;
      if (hit_any_o !== (n == 7) || lane_code_o !== ((n == 7) ? 2'd2 : 2'd0)) begin
        failCount++;
        $display("[TB] FAIL single_code edge %0d: hit_any=%b lane_code=%0d", n, hit_any_o, lane_code_o);
      end
    end
    btn_i = 4'b0000;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (release_o !== ((n == 7) ? 4'b0100 : 4'b0000) || level_o !== ((n >= 7) ? 4'b0000 : 4'b0100)
          || press_o !== 4'b0000) begin
        failCount++;
        $display("[TB] FAIL single_release edge %0d: release=%b level=%b press=%b",
                 n, release_o, level_o, press_o);
      end
    end
  endtask

  task automatic test_glitch();
    $display("[TB] test_glitch");
    for (int n = 0; n < 20; n++) begin
      btn_i = (n < 12 && (n % 2 == 0)) ? 4'b0010 : 4'b0000;
      step();
      assertCount++;
      if (level_o !== 4'h0 || press_o !== 4'h0 || release_o !== 4'h0) begin
        failCount++;
        $display("[TB] FAIL glitch cycle %0d: level=%b press=%b release=%b, expected all zero",
                 n, level_o, press_o, release_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    btn_i = 4'b1010;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (press_o !== ((n == 7) ? 4'b1010 : 4'b0000) || hit_any_o !== (n == 7)
          || lane_code_o !== ((n == 7) ? 2'd1 : 2'd0)) begin
        failCount++;
        $display("[TB] FAIL simultaneous edge %0d: press=%b hit_any=%b lane_code=%0d, expected press=%b",
                 n, press_o, hit_any_o, lane_code_o, (n == 7) ? 4'b1010 : 4'b0000);
      end
    end
    btn_i = 4'b0000;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (release_o !== ((n == 7) ? 4'b1010 : 4'b0000)) begin
        failCount++;
        $display("[TB] FAIL simultaneous_release edge %0d: release=%b", n, release_o);
      end
    end
  endtask

  task automatic test_enable();
    int levelEdge;
    $display("[TB] test_enable");
    en_i = 1'b0; btn_i = 4'b0001;
    levelEdge = 0;
    for (int n = 1; n <= 20 && levelEdge == 0; n++) begin
      step();
      assertCount++;
      if (press_o !== 4'h0 || hit_any_o !== 1'b0 || lane_code_o !== 2'd0) begin
        failCount++;
        $display("[TB] FAIL enable_masked edge %0d: press=%b hit_any=%b", n, press_o, hit_any_o);
      end
      if (level_o[0] === 1'b1) levelEdge = n;
    end
    assertCount++;
    if (levelEdge != 7) begin
      failCount++;
      $display("[TB] FAIL enable_level_latency: level[0] rose at edge %0d (0 = never), expected 7", levelEdge);
    end
    en_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      assertCount++;
      if (press_o !== 4'h0 || level_o !== 4'b0001) begin
        failCount++;
        $display("[TB] FAIL enable_no_replay cycle %0d: press=%b level=%b", n, press_o, level_o);
      end
    end
    btn_i = 4'b0000;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (release_o !== ((n == 7) ? 4'b0001 : 4'b0000)) begin
        failCount++;
        $display("[TB] FAIL enable_release edge %0d: release=%b", n, release_o);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    $display("[TB] test_reset_mid_hold");
    btn_i = 4'b1000;
    for (int n = 0; n < 8; n++) step();
    assertCount++;
    if (level_o !== 4'b1000) begin
      failCount++;
      $display("[TB] FAIL midhold_level: level=%b expected 1000", level_o);
    end
    clr_i = 1'b1;
    step();
    assertCount++;
    if (level_o !== 4'h0 || press_o !== 4'h0 || release_o !== 4'h0) begin
      failCount++;
      $display("[TB] FAIL midhold_clear: level=%b press=%b release=%b", level_o, press_o, release_o);
    end
    clr_i = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      assertCount++;
      if (press_o !== ((n == 7) ? 4'b1000 : 4'b0000) || level_o !== ((n >= 7) ? 4'b1000 : 4'b0000)
          || lane_code_o !== ((n == 7) ? 2'd3 : 2'd0) || release_o !== 4'h0) begin
        failCount++;
        $display("[TB] FAIL midhold_repress edge %0d: press=%b level=%b lane_code=%0d release=%b",
                 n, press_o, level_o, lane_code_o, release_o);
      end
    end
    btn_i = 4'b0000;
    for (int n = 0; n < 9; n++) step();
  endtask

  initial begin
    clr_i = 1'b1; btn_i = 4'h0; en_i = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_back_to_back();
    test_enable();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/lane_key_conditioner.md
Name: lane_key_conditioner

Overview:
Conditions the four raw lane buttons of the game controller into clean, clock-aligned lane events. Each lane is synchronised and debounced, then edge-detected. The block drives the 4-bit lane hit register that sits downstream: press pulses become its load data, and the debounced level is available for hold-note scoring. Synthesises to one instance per controller; all lanes are identical and independent except for the shared priority encoder.

Parameters:
DEB_CYCLES, 250000, consecutive stable samples required to accept a level change (5 ms at 50 MHz); legal range is 2 or more.
CNT_W, 18, debounce counter width; must satisfy 2^CNT_W >= DEB_CYCLES.

Ports:
C  in  1  system clock; all state updates on the rising edge.
clr  in  1  synchronous reset, active-high.
btn  in  4  raw lane buttons, active-high, asynchronous to C, may bounce.
en  in  1  game-running enable; gates event outputs only.
level  out  4  debounced lane state, 1 = held.
press  out  4  one-cycle pulse per lane on accepted press.
release  out  4  one-cycle pulse per lane on accepted release.
hit_any  out  1  OR of press[3:0].
lane_code  out  2  index of the lowest-numbered lane pulsing press this cycle; 0 when hit_any=0.

Behaviour:
- Reset: clr=1 at a rising edge forces sync flops=0, counters=0, all lane FSMs=IDLE, and level/press/release/hit_any/lane_code=0 from the next cycle. clr has priority over every other input. Reset mid-hold is legal: a still-held button is re-debounced and generates a fresh press.
- Synchroniser: 2-flop chain per lane. s[i] is btn[i] delayed 2 edges. Only s[i] feeds the FSM.
- Per-lane FSM has four states: IDLE (level 0), ARM_ON (level 0), HELD (level 1), ARM_OFF (level 1).
  - IDLE: if s=1, go to ARM_ON with cnt=0.
  - ARM_ON: if s=0, go to IDLE with cnt=0 (bounce rejected). Otherwise, if cnt==DEB_CYCLES-1, go to HELD; else cnt++.
  - HELD: if s=0, go to ARM_OFF with cnt=0.
  - ARM_OFF: if s=1, go to HELD with cnt=0. Otherwise, if cnt==DEB_CYCLES-1, go to IDLE; else cnt++.
- Outputs are registered. level[i]=1 in HELD or ARM_OFF.
- press[i] is high for exactly the first cycle in which level[i] reads 1, i.e. the cycle after the ARM_ON to HELD transition.
- release[i] is high for exactly the first cycle in which level[i] reads 0 after being 1.
- Latency: btn[i] stable high starting before edge k gives level/press high after edge k+DEB_CYCLES+2 (DEB_CYCLES+3 edges including edge k). Release latency is identical.
- A glitch shorter than DEB_CYCLES samples never changes level and produces no pulse.
- en=0 forces press, release, hit_any and lane_code to 0. FSMs and level keep running, so an event suppressed while en=0 is lost and is not replayed when en rises. en is sampled on the same edge as the registered pulse.
- Simultaneous presses: all corresponding press bits assert in the same cycle. lane_code is the priority encode, lowest index wins. hit_any is registered in the same cycle as press.
- press and release for the same lane can never be high in the same cycle. The minimum spacing between them is DEB_CYCLES+1 cycles.
- The counter saturates by construction and never wraps; no counter value at or above DEB_CYCLES is reachable.

Test Plan (DEB_CYCLES=4, CNT_W=3):
- Assert clr for 2 cycles with btn=4'hF. Response: all outputs 0 during reset and the cycle after. press=4'hF and lane_code=0 appear 7 edges after clr deasserts.
- btn[2] rises and is held with en=1. Response: level[2]=1, press=4'b0100, hit_any=1, lane_code=2 for exactly 1 cycle, 7 edges after the first sampling edge. Dropping btn[2] gives release=4'b0100 after 7 edges.
- btn[1] toggles 1,0,1,0 every cycle for 12 cycles, then stays 0. Response: level[1], press and release stay 0 throughout.
- btn=4'b1010 rises on the same edge. Response: press=4'b1010 in one cycle, hit_any=1, lane_code=1.
- Hold btn[0] with en=0 until level[0]=1, then set en=1. Response: press stays 0 and is never replayed. level[0]=1 is still observed.
- btn[3] is held. Reset is pulsed for 1 cycle after level[3]=1. Response: level[3] drops to 0, then a new press[3] pulse arrives 7 edges after clr falls.
